// File: rtl/ariele_slave_arb_pkg.sv
// Shared constants and packed-bus field helpers for the ariele slave-port arbiter.
package ariele_arb_pkg;

    localparam int MAX_NM = 8;

    // Width of a master index; at least one bit so NM=1 still elaborates.
    function automatic int id_w(input int nm);
        return (nm > 1) ? $clog2(nm) : 1;
    endfunction

    function automatic logic [31:0] get_word(input logic [32*MAX_NM-1:0] v, input logic [2:0] k);
        return v[32*k +: 32];
    endfunction

    function automatic logic [3:0] get_be(input logic [4*MAX_NM-1:0] v, input logic [2:0] k);
        return v[4*k +: 4];
    endfunction

endpackage

// File: rtl/ariele_slave_arb_if.sv
// Bundles the NM master-side ports and the single slave-side port of the arbiter.
interface ariele_slave_arb_if #(parameter int NM = 4);
    logic [NM-1:0]      m_req_i;
    logic [NM-1:0]      m_we_i;
    logic [32*NM-1:0]   m_addr_bi;
    logic [4*NM-1:0]    m_be_i;
    logic [32*NM-1:0]   m_wdata_bi;
    logic [NM-1:0]      m_ack_o;
    logic [NM-1:0]      m_resp_o;
    logic [31:0]        m_rdata_bo;

    logic               s_req_o;
    logic               s_we_o;
    logic [31:0]        s_addr_bo;
    logic [3:0]         s_be_o;
    logic [31:0]        s_wdata_bo;
    logic               s_ack_i;
    logic               s_resp_i;
    logic [31:0]        s_rdata_bi;

    modport arb (
        input  m_req_i, m_we_i, m_addr_bi, m_be_i, m_wdata_bi,
        output m_ack_o, m_resp_o, m_rdata_bo,
        output s_req_o, s_we_o, s_addr_bo, s_be_o, s_wdata_bo,
        input  s_ack_i, s_resp_i, s_rdata_bi
    );

    modport master (
        output m_req_i, m_we_i, m_addr_bi, m_be_i, m_wdata_bi,
        input  m_ack_o, m_resp_o, m_rdata_bo
    );

    modport slave (
        input  s_req_o, s_we_o, s_addr_bo, s_be_o, s_wdata_bo,
        output s_ack_i, s_resp_i, s_rdata_bi
    );
endinterface

// File: rtl/ariele_slave_arb_id_fifo.sv
// In-order queue of master IDs for reads that are still awaiting a slave response.
module ariele_id_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    // Push is refused when full even if a pop happens this cycle: no resp->req path.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    // Head is read combinationally so the response can be routed in the same cycle.
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end
endmodule

// File: rtl/ariele_slave_arb.sv
// Round-robin arbiter sharing one slave port among NM masters; read responses are
// routed back in issue order via an ID FIFO.
module ariele_slave_arb
    import ariele_arb_pkg::*;
#(
    parameter int NM       = 4,
    parameter int RD_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             arst_i,
    ariele_slave_arb_if.arb  bus,
    output logic             err_o
);
    localparam int ID_W = id_w(NM);

    logic [ID_W-1:0]       rr_ptr_reg;
    logic [ID_W-1:0]       lock_id_reg;
    logic                  lock_reg;
    logic                  err_reg;

    logic [ID_W-1:0]       grant;
    logic [ID_W-1:0]       pick_elig;
    logic [ID_W-1:0]       pick_req;
    logic [ID_W-1:0]       fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [NM-1:0]         eligible;
    logic                  gnt_req;
    logic                  gnt_we;
    logic                  rd_blocked;
    logic                  s_req;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  dropped;
    logic [32*MAX_NM-1:0]  addr_ext;
    logic [32*MAX_NM-1:0]  wdata_ext;
    logic [4*MAX_NM-1:0]   be_ext;

    // First set bit of mask searching upward from start, modulo NM.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NM-1:0] mask, input logic [ID_W-1:0] start);
        int idx;
        rr_pick = start;
        for (int i = NM - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % NM;
            if (mask[idx]) rr_pick = ID_W'(idx);
        end
    endfunction

    // Reads stalled by a full FIFO step aside so a pending write can still win.
    assign eligible  = bus.m_req_i & (bus.m_we_i | {NM{~fifo_full}});
    assign pick_elig = rr_pick(eligible, rr_ptr_reg);
    assign pick_req  = rr_pick(bus.m_req_i, rr_ptr_reg);
    assign grant     = lock_reg ? lock_id_reg : ((|eligible) ? pick_elig : pick_req);

    assign gnt_req    = bus.m_req_i[grant];
    assign gnt_we     = bus.m_we_i[grant];
    assign rd_blocked = ~gnt_we & fifo_full;
    assign s_req      = gnt_req & ~rd_blocked & ~arst_i;
    assign accept     = s_req & bus.s_ack_i;
    assign push       = accept & ~gnt_we;
    assign pop        = bus.s_resp_i & ~fifo_empty & ~arst_i;
    assign dropped    = lock_reg & ~bus.m_req_i[lock_id_reg];

    always_comb begin
        addr_ext  = '0;
        wdata_ext = '0;
        be_ext    = '0;
        addr_ext[32*NM-1:0]  = bus.m_addr_bi;
        wdata_ext[32*NM-1:0] = bus.m_wdata_bi;
        be_ext[4*NM-1:0]     = bus.m_be_i;
    end

    assign bus.s_req_o    = s_req;
    assign bus.s_we_o     = gnt_we & ~arst_i;
    assign bus.s_addr_bo  = arst_i ? '0 : get_word(addr_ext, 3'(grant));
    assign bus.s_wdata_bo = arst_i ? '0 : get_word(wdata_ext, 3'(grant));
    assign bus.s_be_o     = arst_i ? '0 : get_be(be_ext, 3'(grant));
    assign bus.m_rdata_bo = arst_i ? '0 : bus.s_rdata_bi;
    assign err_o          = err_reg;

    for (genvar gi = 0; gi < NM; gi++) begin : g_route
        assign bus.m_ack_o[gi]  = accept & (grant == ID_W'(gi));
        assign bus.m_resp_o[gi] = pop & (fifo_head == ID_W'(gi));
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rr_ptr_reg  <= '0;
            lock_reg    <= 1'b0;
            lock_id_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            if (accept) begin
                lock_reg   <= 1'b0;
                rr_ptr_reg <= (grant == ID_W'(NM - 1)) ? '0 : grant + 1'b1;
            end else if (s_req) begin
                // Hold the grant until the slave accepts.
                lock_reg    <= 1'b1;
                lock_id_reg <= grant;
            end else if (dropped) begin
                lock_reg <= 1'b0;
            end
            if (dropped || (bus.s_resp_i && fifo_empty)) err_reg <= 1'b1;
        end
    end

    ariele_id_fifo #(
        .W     (ID_W),
        .DEPTH (RD_DEPTH)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .push   (push),
        .din    (grant),
        .pop    (pop),
        .dout   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );
endmodule

// File: tb/tb_ariele_slave_arb.sv
// Directed, table-driven check of ariele_slave_arb with NM=4, RD_DEPTH=4.
module tb_ariele_slave_arb;

    logic clk;
    logic arst;
    logic err;

    ariele_slave_arb_if #(.NM(4)) bus ();

    ariele_slave_arb #(.NM(4), .RD_DEPTH(4)) dut (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus),
        .err_o  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        logic        ack;
        logic        resp;
        logic [31:0] rdata;
        logic        esreq;
        int          egnt;
        logic [3:0]  emack;
        logic [3:0]  emresp;
        logic        eerr;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] be_tab [4] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001};

    function automatic logic [31:0] addr_of(input int k);
        return 32'h8000_0000 + 32'(16 * k);
    endfunction

    function automatic logic [31:0] wdata_of(input int k);
        return 32'hD000_0000 + 32'(k);
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] req, input logic [3:0] we, input logic ack, input logic resp,
                       input logic esreq, input int egnt, input logic [3:0] emack,
                       input logic [3:0] emresp, input logic eerr);
        vec_t v;
        v.req = req; v.we = we; v.ack = ack; v.resp = resp;
        v.rdata = 32'h5A5A_0000 | 32'(vecs.size());
        v.esreq = esreq; v.egnt = egnt; v.emack = emack; v.emresp = emresp; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        bus.m_req_i    = '0;
        bus.m_we_i     = '0;
        bus.s_ack_i    = 1'b0;
        bus.s_resp_i   = 1'b0;
        bus.s_rdata_bi = '0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            @(posedge clk);
            #1;
            bus.m_req_i    = vecs[r].req;
            bus.m_we_i     = vecs[r].we;
            bus.s_ack_i    = vecs[r].ack;
            bus.s_resp_i   = vecs[r].resp;
            bus.s_rdata_bi = vecs[r].rdata;
            @(negedge clk);
            $display("row %0d req=%b we=%b s_req=%b s_addr=%h m_ack=%b m_resp=%b err=%b",
                     r, vecs[r].req, vecs[r].we, bus.s_req_o, bus.s_addr_bo, bus.m_ack_o, bus.m_resp_o, err);
            chk("s_req", r, 32'(bus.s_req_o), 32'(vecs[r].esreq));
            chk("m_ack", r, 32'(bus.m_ack_o), 32'(vecs[r].emack));
            chk("m_resp", r, 32'(bus.m_resp_o), 32'(vecs[r].emresp));
            chk("err", r, 32'(err), 32'(vecs[r].eerr));
            if (vecs[r].esreq) begin
                chk("s_addr", r, bus.s_addr_bo, addr_of(vecs[r].egnt));
                chk("s_be", r, 32'(bus.s_be_o), 32'(be_tab[vecs[r].egnt]));
                chk("s_wdata", r, bus.s_wdata_bo, wdata_of(vecs[r].egnt));
                chk("s_we", r, 32'(bus.s_we_o), 32'(vecs[r].we[vecs[r].egnt]));
            end
            if (vecs[r].emresp != 4'b0000)
                chk("m_rdata", r, bus.m_rdata_bo, vecs[r].rdata);
        end
    endtask

    task automatic pulse_reset();
        #2 arst = 1'b1;
        #1;
        $display("reset asserted s_req=%b m_ack=%b err=%b", bus.s_req_o, bus.m_ack_o, err);
        chk("rst_s_req", -1, 32'(bus.s_req_o), 32'd0);
        chk("rst_m_ack", -1, 32'(bus.m_ack_o), 32'd0);
        chk("rst_err", -1, 32'(err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive_idle();
        arst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            bus.m_addr_bi[32*k +: 32]  = addr_of(k);
            bus.m_wdata_bi[32*k +: 32] = wdata_of(k);
            bus.m_be_i[4*k +: 4]       = be_tab[k];
        end

        //   req      we       ack   resp  esreq gnt mack     mresp    err
        // two readers, responses two cycles behind
        add(4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 4'b0000, 1'b0);  // 0
        add(4'b0101, 4'b0000, 1'b1, 1'b0, 1'b1, 2, 4'b0100, 4'b0000, 1'b0);
        add(4'b0101, 4'b0000, 1'b1, 1'b1, 1'b1, 0, 4'b0001, 4'b0001, 1'b0);
        add(4'b0101, 4'b0000, 1'b1, 1'b1, 1'b1, 2, 4'b0100, 4'b0100, 1'b0);
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 4'b0001, 1'b0);
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 4'b0100, 1'b0);  // 5
        // m1 write held off by the slave for three cycles
        add(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 4'b0000, 1'b0);
        add(4'b1010, 4'b1010, 1'b0, 1'b0, 1'b1, 1, 4'b0000, 4'b0000, 1'b0);
        add(4'b1011, 4'b1010, 1'b0, 1'b0, 1'b1, 1, 4'b0000, 4'b0000, 1'b0);
        add(4'b1010, 4'b1010, 1'b0, 1'b0, 1'b1, 1, 4'b0000, 4'b0000, 1'b0);
        add(4'b1010, 4'b1010, 1'b1, 1'b0, 1'b1, 1, 4'b0010, 4'b0000, 1'b0);  // 10
        add(4'b1000, 4'b1000, 1'b1, 1'b0, 1'b1, 3, 4'b1000, 4'b0000, 1'b0);
        // fill the ID FIFO with 3,2,1,0
        add(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 3, 4'b1000, 4'b0000, 1'b0);
        add(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 2, 4'b0100, 4'b0000, 1'b0);
        add(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1, 1, 4'b0010, 4'b0000, 1'b0);
        add(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 4'b0000, 1'b0);  // 15
        // full: m0 read stalls, m1 write goes through
        add(4'b0011, 4'b0010, 1'b1, 1'b0, 1'b1, 1, 4'b0010, 4'b0000, 1'b0);
        add(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 0, 4'b0000, 4'b1000, 1'b0);
        add(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 4'b0000, 1'b0);
        // full with a pop in the same cycle: read still refused
        add(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 1, 4'b0000, 4'b0100, 1'b0);
        add(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 1, 4'b0010, 4'b0010, 1'b0);  // 20
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 4'b0001, 1'b0);
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 4'b0001, 1'b0);
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 4'b0010, 1'b0);
        // pop ID 3 while m1 read is accepted
        add(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 3, 4'b1000, 4'b0000, 1'b0);
        add(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1, 1, 4'b0010, 4'b1000, 1'b0);  // 25
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 4'b0010, 1'b0);
        // response with empty FIFO: sticky error
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 1'b1);
        add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 1'b1);
        // two reads outstanding then a locked write
        add(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 4'b0000, 1'b1);  // 30
        add(4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 2, 4'b0100, 4'b0000, 1'b1);
        add(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1, 1, 4'b0000, 4'b0000, 1'b1);
        // after reset: 4-way tie goes to m0, FIFO empty
        add(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 0, 4'b0001, 4'b0000, 1'b0);  // 33
        add(4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 0, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 1'b1);
        // locked master drops its request
        add(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, 2, 4'b0000, 4'b0000, 1'b0);  // 36
        add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 1'b0);
        add(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 4'b0000, 1'b1);

        // Requests driven during reset must not leak to the outputs.
        arst = 1'b1;
        drive_idle();
        bus.m_req_i = 4'b1111;
        bus.s_ack_i = 1'b1;
        bus.s_resp_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("in reset s_req=%b m_ack=%b m_resp=%b err=%b", bus.s_req_o, bus.m_ack_o, bus.m_resp_o, err);
        chk("init_s_req", -1, 32'(bus.s_req_o), 32'd0);
        chk("init_m_ack", -1, 32'(bus.m_ack_o), 32'd0);
        chk("init_m_resp", -1, 32'(bus.m_resp_o), 32'd0);
        chk("init_err", -1, 32'(err), 32'd0);
        drive_idle();
        arst = 1'b0;

        run_rows(0, 32);
        pulse_reset();
        run_rows(33, 35);
        pulse_reset();
        run_rows(36, 38);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ariele_slave_arb.md
Name: ariele_slave_arb

Overview:
Round-robin arbiter that shares one MemSplit32-style slave port (req/we/addr/be/wdata/ack/resp/rdata) among NM masters. It sits in front of a single-ported slave, such as a tile HPI or gpio, when several bus agents target it without going through the full crossbar. It forwards the winning request with zero added latency and tracks outstanding reads in order, so each read response returns to the master that issued it.

Parameters:
NM, 4, number of masters (2..8)
RD_DEPTH, 4, max outstanding reads (power of 2, >=2)

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous reset, active-high
m_req_i  in  NM  per-master request
m_we_i  in  NM  per-master write enable (1=write, 0=read)
m_addr_bi  in  32*NM  master k address at [32k+31:32k]
m_be_i  in  4*NM  byte enables, packed the same way
m_wdata_bi  in  32*NM  write data, packed
m_ack_o  out  NM  request accepted, one-hot or zero
m_resp_o  out  NM  read response valid, one-hot or zero
m_rdata_bo  out  32  read data, broadcast to all masters; qualified by m_resp_o
s_req_o, s_we_o  out  1  slave request / write enable
s_addr_bo  out  32  slave address
s_be_o  out  4  slave byte enables
s_wdata_bo  out  32  slave write data
s_ack_i, s_resp_i  in  1  slave accept / read response
s_rdata_bi  in  32  slave read data
err_o  out  1  sticky protocol error flag

Behaviour:
- Clock and reset: one clock, clk_i; arst_i is asynchronous and active-high, and all state clears immediately on assertion.
- Reset values: rr_ptr=0, lock=0, lock_id=0, FIFO empty, err_o=0.
  - Combinational outputs are 0 while arst_i is high.
- Request stage:
  - Select: if lock=1, grant=lock_id; otherwise grant is the first set m_req_i bit searching from rr_ptr upward, modulo NM.
  - Issue: s_req_o = m_req_i[grant] & !(rd_blocked), where rd_blocked = !m_we_i[grant] & fifo_full.
  - s_we/addr/be/wdata mux from the granted master combinationally.
  - m_ack_o[grant] = s_req_o & s_ack_i; all other ack bits are 0.
- Lock: on a cycle with s_req_o=1 and s_ack_i=0, set lock=1 and lock_id=grant.
  - The grant stays stable until the request is accepted, so the slave sees no change mid-handshake.
- Accept: on s_req_o & s_ack_i, clear lock and set rr_ptr=(grant+1) mod NM.
  - If the accepted request is a read, push grant into the ID FIFO.
- Read-stall rule: a read blocked by a full FIFO does not set lock.
  - Re-arbitration may then pick a write from another master; writes are never blocked by a full FIFO.
- No full-bypass: push is refused when the FIFO is full, even if a pop occurs in the same cycle. This avoids a resp->req combinational path.
- A master that drops m_req_i while locked without being acked is a master protocol violation: set err_o=1 and clear lock.
- Response stage:
  - On s_resp_i with the FIFO non-empty: m_resp_o[head]=1, m_rdata_bo=s_rdata_bi, pop the FIFO. The response is passed through in the same cycle.
  - Responses are in-order per the slave contract.
  - s_resp_i with the FIFO empty: no m_resp_o bit set, err_o=1 (sticky until reset).
- Simultaneous push and pop in one cycle (FIFO not full) is legal: count unchanged, pointers both advance.
- Pointer widths: clog2(RD_DEPTH), wrapping naturally; the count is one bit wider to distinguish full from empty.
- Reset during an outstanding transaction: all tracking is dropped. Slaves are expected to be reset by the same srst domain.
- Latency: request 0 cycles, response 0 cycles; no bubbles between back-to-back accepted requests.

Decomposition:
- Package ariele_arb_pkg: ID_W=$clog2(NM) helper function, MAX_NM=8, packed-field extract macros/functions for addr/be/wdata.
- Sub-module ariele_id_fifo: synchronous FIFO with width ID_W and depth RD_DEPTH.
  - Ports: clk_i, arst_i, push, din, pop, dout, full, empty.
- Arbiter logic stays in the parent.

Test Plan:
- Masters 0 and 2 both issue reads; slave acks every cycle with resp 2 cycles later.
  -> ack order m0, m2, m0, m2; resp to m0 with data A, then m2 with data B; rr_ptr alternates.
- Master 1 issues a write at addr 0x80000010, be=4'b0011; slave holds s_ack_i=0 for 3 cycles while m3 also requests.
  -> s_addr_bo stays 0x80000010 for all 4 cycles; m_ack_o=4'b0010 only on cycle 4; m3 granted on cycle 5.
- RD_DEPTH=4: issue 4 reads with no resp, then m0 requests a read and m1 a write.
  -> m0 read is stalled (s_req_o not asserted for it); m1 write is accepted.
  -> After one s_resp_i, the m0 read issues the next cycle.
- Same cycle: s_resp_i pops ID 3 while a read from m1 is accepted.
  -> m_resp_o=4'b1000; FIFO count unchanged; next resp goes to the following queued ID.
- s_resp_i pulses with the FIFO empty.
  -> m_resp_o=0, err_o rises the next cycle and stays 1 until arst_i.
- Assert arst_i mid-lock with 2 reads outstanding.
  -> s_req_o=0 immediately; after release rr_ptr=0, FIFO empty, and master 0 wins a 4-way tie.
